// File: rtl/alu_seq_pkg.sv
// alu_seq shared types.
// Opcodes, FSM states and the flag bundle.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_ASR = 4'd8,
    OP_MUL = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
    logic e;
  } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq operand/result handshake bundle.
// master = issue/writeback side, slave = ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             zf;
  logic             nf;
  logic             cf;
  logic             vf;
  logic             ef;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, r,
    input  zf, nf, cf, vf, ef
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, r,
    output zf, nf, cf, vf, ef
  );
endinterface

// File: rtl/alu_seq_iter.sv
// alu_seq iterative engine: shifts and
// shift-add multiply, one step per cycle.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    r_acc;
  logic [W2-1:0]    r_mcd;
  logic [WIDTH-1:0] r_mpr;
  logic [SHW-1:0]   r_cnt;
  logic             r_last;
  logic             r_run;
  op_e              r_op;

  op_e              w_op;
  logic [W2-1:0]    w_acc;
  logic [W2-1:0]    w_mcd;
  logic [WIDTH-1:0] w_mpr;
  logic [W2-1:0]    w_nacc;
  logic [W2-1:0]    w_nmcd;
  logic [WIDTH-1:0] w_nmpr;
  logic             w_nlast;

  // One step; the first step is folded
  // into the load so BUSY runs n-1 more.
  always_comb begin
    w_op    = r_op;
    w_acc   = r_acc;
    w_mcd   = r_mcd;
    w_mpr   = r_mpr;
    if (i_start) begin
      w_op  = i_op;
      w_mcd = {{WIDTH{1'b0}}, i_a};
      w_mpr = i_b;
      if (i_op == OP_MUL)
        w_acc = '0;
      else
        w_acc = {{WIDTH{1'b0}}, i_a};
    end
    w_nacc  = w_acc;
    w_nmcd  = w_mcd;
    w_nmpr  = w_mpr;
    w_nlast = r_last;
    case (w_op)
      OP_SHL: begin
        w_nacc  = {{WIDTH{1'b0}},
                   w_acc[WIDTH-2:0], 1'b0};
        w_nlast = w_acc[WIDTH-1];
      end
      OP_SHR: begin
        w_nacc  = {{WIDTH{1'b0}},
                   1'b0, w_acc[WIDTH-1:1]};
        w_nlast = w_acc[0];
      end
      OP_ASR: begin
        w_nacc  = {{WIDTH{1'b0}},
                   w_acc[WIDTH-1],
                   w_acc[WIDTH-1:1]};
        w_nlast = w_acc[0];
      end
      OP_MUL: begin
        w_nacc = w_mpr[0] ? (w_acc + w_mcd)
                          : w_acc;
        w_nmcd = w_mcd << 1;
        w_nmpr = w_mpr >> 1;
      end
      default: ;
    endcase
  end

  // Datapath registers and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_mcd  <= '0;
      r_mpr  <= '0;
      r_cnt  <= '0;
      r_last <= 1'b0;
      r_run  <= 1'b0;
      r_op   <= OP_ADD;
    end else if (i_start) begin
      r_acc  <= w_nacc;
      r_mcd  <= w_nmcd;
      r_mpr  <= w_nmpr;
      r_last <= w_nlast;
      r_op   <= i_op;
      r_run  <= 1'b1;
      if (i_op == OP_MUL)
        r_cnt <= SHW'(WIDTH - 1);
      else
        r_cnt <= i_b[SHW-1:0] - SHW'(1);
    end else if (r_run) begin
      if (r_cnt != '0) begin
        r_acc  <= w_nacc;
        r_mcd  <= w_nmcd;
        r_mpr  <= w_nmpr;
        r_last <= w_nlast;
        r_cnt  <= r_cnt - SHW'(1);
      end else begin
        r_run  <= 1'b0;
      end
    end
  end

  assign o_done   = r_run && (r_cnt == '0);
  assign o_result = r_acc[WIDTH-1:0];
  assign o_carry  = (r_op == OP_MUL)
                  ? (|r_acc[W2-1:WIDTH])
                  : r_last;

endmodule

// File: rtl/alu_seq.sv
// alu_seq top: FSM, single-cycle ops,
// flag generation and output registers.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_res;
  flags_t           r_flags;

  op_e              w_op;
  logic             w_accept;
  logic             w_shift;
  logic             w_multi;
  logic             w_start;
  logic             w_eng_done;
  logic             w_eng_c;
  logic [WIDTH-1:0] w_eng_r;
  logic [WIDTH-1:0] w_sc_r;
  flags_t           w_sc_f;
  flags_t           w_eng_f;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;

  assign w_op     = op_e'(bus.op);
  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_shift  = (w_op == OP_SHL) ||
                    (w_op == OP_SHR) ||
                    (w_op == OP_ASR);
  assign w_multi  = (w_op == OP_MUL) ||
                    (w_shift &&
                     (|bus.b[SHW-1:0]));
  assign w_add = {1'b0, bus.a}
               + {1'b0, bus.b};
  assign w_sub = {1'b0, bus.a}
               - {1'b0, bus.b};

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_op     (w_op),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_done   (w_eng_done),
    .o_result (w_eng_r),
    .o_carry  (w_eng_c)
  );

  // Single-cycle result and flags.
  always_comb begin
    w_sc_r = '0;
    w_sc_f = '0;
    case (w_op)
      OP_ADD: begin
        w_sc_r   = w_add[WIDTH-1:0];
        w_sc_f.c = w_add[WIDTH];
        w_sc_f.v =
          (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
          (w_add[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_r   = w_sub[WIDTH-1:0];
        w_sc_f.c = w_sub[WIDTH];
        w_sc_f.v =
          (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
          (w_sub[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: w_sc_r = bus.a & bus.b;
      OP_OR:  w_sc_r = bus.a | bus.b;
      OP_XOR: w_sc_r = bus.a ^ bus.b;
      OP_NOT: w_sc_r = ~bus.a;
      OP_SHL, OP_SHR, OP_ASR:
        w_sc_r = bus.a;
      OP_MUL: w_sc_r = '0;
      default: w_sc_f.e = 1'b1;
    endcase
    w_sc_f.z = (w_sc_r == '0);
    w_sc_f.n = w_sc_r[WIDTH-1];
  end

  // Flags for an iterative result.
  always_comb begin
    w_eng_f   = '0;
    w_eng_f.z = (w_eng_r == '0);
    w_eng_f.n = w_eng_r[WIDTH-1];
    w_eng_f.c = w_eng_c;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state and engine launch.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_multi) begin
            w_next  = ST_BUSY;
            w_start = 1'b1;
          end else begin
            w_next  = ST_DONE;
          end
        end
      end
      ST_BUSY:
        if (w_eng_done) w_next = ST_DONE;
      ST_DONE:
        if (bus.out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Result registers, loaded on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res   <= '0;
      r_flags <= '0;
    end else if (r_state == ST_IDLE &&
                 w_accept && !w_multi) begin
      r_res   <= w_sc_r;
      r_flags <= w_sc_f;
    end else if (r_state == ST_BUSY &&
                 w_eng_done) begin
      r_res   <= w_eng_r;
      r_flags <= w_eng_f;
    end
  end

  assign bus.r  = r_res;
  assign bus.zf = r_flags.z;
  assign bus.nf = r_flags.n;
  assign bus.cf = r_flags.c;
  assign bus.vf = r_flags.v;
  assign bus.ef = r_flags.e;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the team's 4-bit combinational ALU. It is WIDTH bits wide and adds valid/ready handshakes on both sides, a full flag set (zero, negative, carry, overflow, error), and multi-cycle operations: variable-distance shifts and multiply. It sits between an operand-issue stage and a result-writeback stage, and holds one operation in flight at a time.

## Interface

- WIDTH, 8: operand and result width, ≥ 4, power of two.
- SHW, $clog2(WIDTH): shift-amount width, derived, not overridden.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts.
- op  in  4  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  downstream accepts result.
- r  out  WIDTH  result.
- zf, nf, cf, vf, ef  out  1 each  zero, negative, carry/borrow, signed overflow, illegal-op error.

## Operation

- Opcodes:
  - 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 NOT (~a).
  - 6 SHL, 7 SHR (logical), 8 ASR (arithmetic).
  - 9 MUL: low WIDTH bits of the unsigned product.
  - 10–15 illegal.
- Accept occurs on the edge where in_valid && in_ready. a, b and op are captured at accept; input changes afterwards have no effect.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE on accept for single-cycle ops: 0–5, illegal, and shifts with amount 0.
  - IDLE → BUSY on accept for shifts with amount n ≥ 1 and for MUL.
  - BUSY: one shift step or one shift-add step per cycle, driven by a down-counter. Moves to DONE on the edge after the last step.
  - DONE → IDLE on the edge where out_ready is high.
- Flags:
  - zf = (r == 0); nf = r[WIDTH-1].
  - cf:
    - ADD: carry-out.
    - SUB: borrow, i.e. unsigned a < b.
    - Shifts: the last bit shifted out; 0 when the amount is 0.
    - MUL: 1 when the upper WIDTH bits of the product are nonzero.
    - Logic ops: 0.
  - vf: signed overflow for ADD and SUB; 0 for all other ops.
  - ef: 1 only for illegal ops. Illegal ops also force r = 0 with zf = 1 and all other flags 0.
- The shift amount is b[SHW-1:0] only. A shift by n ≥ WIDTH is impossible by construction.
- r and flags are registered. They update only on the BUSY/IDLE → DONE edge and stay stable while out_valid && !out_ready.
- in_valid is ignored outside IDLE. No queueing.

## Timing

- Reset, asynchronous: state = IDLE. r, zf, nf, cf, vf, ef and out_valid are all 0. in_ready = 1 while and after reset is asserted.
- Reset mid-operation aborts it. No result is emitted and the captured operands are discarded.
- Latency, measured from the accept edge to out_valid high:
  - 1 cycle for single-cycle ops.
  - n+1 cycles for a shift by n ≥ 1.
  - WIDTH+1 cycles for MUL.
- out_valid falls on the edge after out_ready is seen high in DONE; in_ready rises on that same edge.
- Back-to-back throughput, with out_ready held high: one single-cycle op every 2 cycles.
- in_ready is combinational from state only, with no path from in_valid. out_valid is a state decode.

## Structure

- Package alu_seq_pkg holds:
  - the opcode enum;
  - the FSM state enum;
  - a flag struct {z, n, c, v, e}.
- Sub-module alu_seq_iter is the iterative engine. It holds the shift/multiply datapath (accumulator, multiplicand, multiplier registers, step counter, last-out bit) and exposes start, done, result and carry.
- The top level holds the FSM, the single-cycle combinational ops, flag generation and the output registers.

## Test plan

All scenarios use WIDTH = 8.

- ADD a=0x7F, b=0x01 → r=0x80, nf=1, vf=1, cf=0, zf=0; out_valid 1 cycle after accept. SUB 0x03−0x05 → r=0xFE, cf=1, nf=1, vf=0. SUB 0x05−0x05 → r=0x00, zf=1.
- SHL a=0x81, b=3 → r=0x08, cf=0; out_valid 4 cycles after accept. ASR a=0x90, b=2 → r=0xE4, cf=0. SHR a=0x01, b=1 → r=0x00, cf=1, zf=1. SHL with b=0 → r=a, cf=0, latency 1.
- MUL 0x10×0x11 → r=0x10, cf=1; out_valid 9 cycles after accept. MUL 0x0F×0x0F → r=0xE1, cf=0.
- Backpressure: after a result, hold out_ready=0 for 5 cycles while pulsing in_valid with new operands. r and flags stay stable, in_ready stays 0, no new accept occurs. Raising out_ready gives out_valid=0 and in_ready=1 on the next edge.
- Reset mid-MUL, 4 cycles after accept → out_valid=0 and all outputs 0 immediately, in_ready=1. A following ADD 0x02+0x03 → r=0x05.
- Illegal op=0xC, a=0xFF → r=0x00, ef=1, zf=1, cf=vf=nf=0; latency 1.
